// File: rtl/mux_pkg.sv
// Shared types and helpers for the one-hot pipelined operand selector.
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_t;

  localparam int unsigned MAX_NUM_IN = 16;

  // Bits needed to encode an index in 0..n-1, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_classify.sv
// Classifies a select bus as zero-, one- or multi-hot and encodes its lowest set bit.
module onehot_classify
  import mux_pkg::*;
#(
  parameter int unsigned NUM_IN = 8,
  localparam int unsigned SW    = NUM_IN - 1,
  localparam int unsigned IW    = idx_w(SW)
) (
  input  logic [SW-1:0] sel,
  output sel_class_t    sel_class,
  output logic [IW-1:0] idx
);

  logic seen;

  // First set bit from the bottom fixes idx; any further set bit makes it multi-hot.
  always_comb begin
    sel_class = SEL_ZERO;
    idx       = '0;
    seen      = 1'b0;
    for (int i = 0; i < int'(SW); i++) begin
      if (sel[i]) begin
        if (!seen) begin
          idx       = IW'(i);
          seen      = 1'b1;
          sel_class = SEL_ONE;
        end else begin
          sel_class = SEL_MULTI;
        end
      end
    end
  end

endmodule

// File: rtl/onehot_pipe_mux.sv
// Registered N:1 one-hot selector with valid/ready handshake and multi-hot error count.
// ONEHOT_PIPE_MUX_PRIORITY_EN: multi-hot selects resolve to the lowest set bit instead of holding.
module onehot_pipe_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_IN    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-2:0]       in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int unsigned SW = NUM_IN - 1;
  localparam int unsigned IW = idx_w(SW);

  sel_class_t       sel_class;
  logic [IW-1:0]    sel_idx;
  logic [WIDTH-1:0] pick_c;
  logic [WIDTH-1:0] next_data_c;
  logic             accept_c;
  logic             multi_c;

  onehot_classify #(
    .NUM_IN (NUM_IN)
  ) u_classify (
    .sel       (in_sel),
    .sel_class (sel_class),
    .idx       (sel_idx)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;
  assign multi_c  = (sel_class == SEL_MULTI);

  // Input addressed by the lowest set select bit (select bit j maps to input j+1).
  always_comb begin
    pick_c = in_data[WIDTH-1:0];
    for (int k = 1; k < int'(NUM_IN); k++) begin
      if (sel_idx == IW'(k - 1)) pick_c = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    next_data_c = out_data;
    case (sel_class)
      SEL_ZERO:  next_data_c = in_data[WIDTH-1:0];
      SEL_ONE:   next_data_c = pick_c;
`ifdef ONEHOT_PIPE_MUX_PRIORITY_EN
      SEL_MULTI: next_data_c = pick_c;
`else
      SEL_MULTI: next_data_c = out_data;
`endif
      default:   next_data_c = out_data;
    endcase
  end

  // Output stage: load on accept, drop valid on drain, freeze while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      sel_err <= 1'b0;
      if (accept_c) begin
        out_data  <= next_data_c;
        out_valid <= 1'b1;
        sel_err   <= multi_c;
        if (multi_c && (err_cnt != {ERR_CNT_W{1'b1}})) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_pipe_mux.sv
// Directed self-checking bench for onehot_pipe_mux (WIDTH=32, NUM_IN=8, ERR_CNT_W=2).
module tb_onehot_pipe_mux;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned NUM_IN    = 8;
  localparam int unsigned ERR_CNT_W = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-2:0]       in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [ERR_CNT_W-1:0]    err_cnt;

  int n_cmp;
  int n_bad;

  onehot_pipe_mux #(
    .WIDTH     (WIDTH),
    .NUM_IN    (NUM_IN),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input logic [31:0] v);
    in_data[k*WIDTH +: WIDTH] = v;
  endtask

  logic [31:0] multi_exp;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-hot selects input 0
    set_in(0, 32'h1234_5678);
    for (int k = 1; k < 8; k++) set_in(k, 32'hA000_0000 | 32'(k));
    in_sel   = 7'b0000000;
    in_valid = 1'b1;
    tick();
    chk("zero_data", out_data, 32'h1234_5678);
    chk("zero_valid", 32'(out_valid), 32'd1);
    chk("zero_sel_err", 32'(sel_err), 32'd0);

    // One-hot sweep on back-to-back cycles
    for (int j = 0; j < 7; j++) begin
      in_sel = 7'(1 << j);
      chk("sweep_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("sweep_data", out_data, 32'hA000_0000 | 32'(j + 1));
      chk("sweep_valid", 32'(out_valid), 32'd1);
    end

    // Stall: held word stays while pending input changes
    in_sel    = 7'b0000100;
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready0", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      set_in(3, 32'hB000_0000 | 32'(c));
      tick();
      chk("stall_data", out_data, 32'hA000_0007);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    set_in(3, 32'hA000_0003);
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("unstall_data", out_data, 32'hA000_0003);

    // Multi-hot accept
`ifdef ONEHOT_PIPE_MUX_PRIORITY_EN
    multi_exp = 32'hA000_0002;
`else
    multi_exp = 32'hA000_0003;
`endif
    in_sel = 7'b0000110;
    tick();
    chk("multi_data", out_data, multi_exp);
    chk("multi_valid", 32'(out_valid), 32'd1);
    chk("multi_sel_err", 32'(sel_err), 32'd1);
    chk("multi_err_cnt", 32'(err_cnt), 32'd1);

    // Drain with a non-accepted multi-hot present
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data", out_data, multi_exp);
    chk("drain_sel_err", 32'(sel_err), 32'd0);
    chk("drain_err_cnt", 32'(err_cnt), 32'd1);

    // Saturation from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_sel   = 7'b0101000;
    in_valid = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("sat_err_cnt", 32'(err_cnt), (n < 3) ? 32'(n) : 32'd3);
      chk("sat_sel_err", 32'(sel_err), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("sat_sel_err_clear", 32'(sel_err), 32'd0);

    // Async reset in the middle of a hold
    in_sel   = 7'b0000001;
    in_valid = 1'b1;
    tick();
    chk("hold_load_data", out_data, 32'hA000_0001);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    chk("hold_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_data", out_data, 32'd0);
    chk("async_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_pipe_mux.md
Name: onehot_pipe_mux

Overview:
- Parametrised, registered N:1 data selector driven by a one-hot select bus; the pipelined-datapath successor of the 32-bit 2:1 operand mux.
- Sits between the register-file/forwarding sources and the ALU operand register in the pipelined CPU.
- Adds a valid/ready handshake with stall hold, zero-hot default, multi-hot detection and a saturating error counter.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 8, number of data inputs; legal range 2..16. Select width is NUM_IN-1 (input 0 is the zero-hot default).
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  NUM_IN-1  one-hot select; bit j selects input j+1; all-zero selects input 0.
- in_valid  in  1  in_data/in_sel are valid this cycle.
- in_ready  out  1  stage can accept; equals !out_valid || out_ready (combinational).
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts out_data.
- sel_err  out  1  one-cycle pulse: an accepted transfer carried a multi-hot in_sel.
- err_cnt  out  ERR_CNT_W  count of multi-hot transfers; saturates at all-ones.

Behaviour:
- Reset (async assert, sync deassert at the next clk edge): out_data=0, out_valid=0, sel_err=0, err_cnt=0. Reset mid-transfer discards the held word.
- Accept = in_valid && in_ready. Latency is 1 cycle: the word appears on out_data/out_valid at the next edge.
- Select classes, decoded combinationally:
  - ZERO (in_sel==0): load input 0.
  - ONE (exactly one bit set): load input j+1.
  - MULTI (two or more bits set): out_data keeps its previous value, out_valid is still set, sel_err pulses for 1 cycle, err_cnt increments unless at all-ones.
- Hold: while out_valid && !out_ready, out_data and out_valid are frozen and in_ready=0. in_data may change freely during the hold.
- Drain: out_valid && out_ready && !in_valid clears out_valid at the next edge; out_data keeps its last value.
- Pass-through: out_valid && out_ready && in_valid accepts the new word in the same cycle. This gives full throughput with no bubble.
- sel_err is 0 in every cycle without a MULTI accept. A non-accepted MULTI (stalled or in_valid=0) has no effect.
- err_cnt: width ERR_CNT_W, no wrap, cleared only by reset.
- No X propagation: in_sel values outside the three classes cannot occur; every case assigns the output.

Optional Feature:
- Macro: ONEHOT_PIPE_MUX_PRIORITY_EN.
- Defined: a MULTI select resolves to the lowest set bit (input j+1 for the lowest j). sel_err still pulses and err_cnt still counts.
- Undefined: MULTI holds the previous out_data as described in Behaviour.

Decomposition:
- Package mux_pkg:
  - enum sel_class_t {SEL_ZERO, SEL_ONE, SEL_MULTI}.
  - localparam MAX_NUM_IN=16.
  - function clog2-based index width helper.
- Sub-module onehot_classify: combinational; input sel[NUM_IN-2:0]; outputs class (sel_class_t) and idx (lowest set bit, encoded).
- The top level holds the register stage, the handshake and the counter.

Test Plan:
- Reset/zero-hot: rst_n low, then high; WIDTH=32, NUM_IN=8; in_data[0]=0x1234_5678, in_sel=0, in_valid=1, out_ready=1 -> next cycle out_data=0x1234_5678, out_valid=1, sel_err=0.
- One-hot sweep: in_sel=7'b0000001 through 7'b1000000 on consecutive cycles, input k=0xA000_000k -> out_data follows one cycle later, 0xA000_0001..0xA000_0007, no bubble.
- Stall: out_ready=0 for 3 cycles while in_data changes -> out_data held, in_ready=0. On out_ready=1 the pending input is accepted the same cycle.
- Multi-hot: previous out_data=0xA000_0003, in_sel=7'b0000110 -> out_data stays 0xA000_0003 (macro off) or becomes 0xA000_0002 (macro on); sel_err=1 for 1 cycle; err_cnt=1.
- Saturation: ERR_CNT_W=2, 5 accepted MULTI transfers -> err_cnt reads 1,2,3,3,3.
- Async reset mid-hold: out_valid=1, out_ready=0, rst_n pulled low between edges -> out_valid=0, out_data=0, err_cnt=0 immediately, without waiting for clk.
